// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: price and coin tables, controller state
// encoding and a constant-evaluable clog2 helper.
`default_nettype none

package vm_pkg;

    localparam int PKG_NUM_ITEMS = 4;
    localparam int PKG_NUM_COINS = 3;
    localparam int PKG_ITEM_IDX_BITS = $clog2(PKG_NUM_ITEMS);
    localparam int PKG_COIN_IDX_BITS = $clog2(PKG_NUM_COINS);

    localparam int unsigned ITEM_PRICE [PKG_NUM_ITEMS] = '{400, 500, 1200, 2500};
    // Coin values must ascend; the change dispenser relies on it.
    localparam int unsigned COIN_VALUE [PKG_NUM_COINS] = '{100, 500, 1000};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RETURN = 1'b1
    } vm_state_t;

    function automatic int vm_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Entries beyond the tables read as 0 so oversized parameterisations elaborate.
    function automatic int unsigned item_price(input int idx);
        if (idx < 0 || idx >= PKG_NUM_ITEMS) begin
            return 0;
        end
        return ITEM_PRICE[idx[PKG_ITEM_IDX_BITS-1:0]];
    endfunction

    function automatic int unsigned coin_value(input int idx);
        if (idx < 0 || idx >= PKG_NUM_COINS) begin
            return 0;
        end
        return COIN_VALUE[idx[PKG_COIN_IDX_BITS-1:0]];
    endfunction

endpackage

`default_nettype wire

// File: rtl/vm_change_dispenser.sv
// Greedy change step: picks the largest coin not exceeding the remaining credit
// and returns the credit left after paying it out.
`default_nettype none

module vm_change_dispenser
    import vm_pkg::*;
#(
    parameter int NUM_COINS  = 3,
    parameter int TOTAL_BITS = 16
) (
    input  logic                  start,
    input  logic [TOTAL_BITS-1:0] remaining,
    output logic [NUM_COINS-1:0]  coin,
    output logic [TOTAL_BITS-1:0] remaining_next,
    output logic                  done
);

    localparam int CIDX_BITS = (vm_clog2(NUM_COINS) < 1) ? 1 : vm_clog2(NUM_COINS);

    logic [TOTAL_BITS-1:0] value [NUM_COINS];

    for (genvar g = 0; g < NUM_COINS; g++) begin : g_value
        assign value[g] = TOTAL_BITS'(coin_value(g));
    end

    always_comb begin
        coin           = '0;
        remaining_next = remaining;
        done           = 1'b0;
        if (start) begin
            // Ascending values: the last coin that fits is the largest one.
            for (int k = 0; k < NUM_COINS; k++) begin
                if (value[k[CIDX_BITS-1:0]] != '0 && value[k[CIDX_BITS-1:0]] <= remaining) begin
                    coin                  = '0;
                    coin[k[CIDX_BITS-1:0]] = 1'b1;
                    remaining_next        = remaining - value[k[CIDX_BITS-1:0]];
                end
            end
            done = (coin == '0);
        end
    end

endmodule

`default_nettype wire

// File: rtl/vending_machine_stock.sv
// Vending controller with per-slot stock, restock, greedy change return,
// inactivity auto-return and over-limit coin rejection.
`default_nettype none

module vending_machine_stock
    import vm_pkg::*;
#(
    parameter int NUM_ITEMS      = 4,
    parameter int NUM_COINS      = 3,
    parameter int TOTAL_BITS     = 16,
    parameter int MAX_TOTAL      = 9900,
    parameter int STOCK_BITS     = 4,
    parameter int INIT_STOCK     = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int IDX_BITS      = (vm_clog2(NUM_ITEMS) < 1) ? 1 : vm_clog2(NUM_ITEMS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic [NUM_ITEMS-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    input  logic                  i_restock_valid,
    input  logic [IDX_BITS-1:0]   i_restock_item,
    input  logic [STOCK_BITS-1:0] i_restock_qty,
    output logic [NUM_ITEMS-1:0]  o_available_item,
    output logic [NUM_ITEMS-1:0]  o_output_item,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic [NUM_COINS-1:0]  o_coin_reject,
    output logic [TOTAL_BITS-1:0] o_current_total,
    output logic [NUM_ITEMS-1:0]  o_sold_out,
    output logic                  o_busy,
    output logic                  o_return_done
);

    localparam int CIDX_BITS = (vm_clog2(NUM_COINS) < 1) ? 1 : vm_clog2(NUM_COINS);
    localparam int TO_BITS   = (vm_clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : vm_clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [STOCK_BITS:0] STOCK_MAX = {1'b0, {STOCK_BITS{1'b1}}};

    vm_state_t             state, state_next;
    logic [TOTAL_BITS-1:0] credit, credit_next;
    logic [TO_BITS-1:0]    idle_count, idle_count_next;
    logic [NUM_ITEMS-1:0]  output_item_next, purchase;
    logic [NUM_COINS-1:0]  return_coin_next, coin_reject_next;
    logic                  return_done_next;

    logic [STOCK_BITS-1:0] stock [NUM_ITEMS];
    logic [TOTAL_BITS-1:0] price [NUM_ITEMS];
    logic [TOTAL_BITS-1:0] value [NUM_COINS];

    logic [NUM_ITEMS-1:0]  want, winner;
    logic [NUM_COINS-1:0]  coin_first;
    logic [TOTAL_BITS-1:0] sel_price, coin_amt;
    logic [TOTAL_BITS:0]   credit_plus;
    logic                  coin_any, select_any, coin_ok;
    logic                  idle_tick, timeout_hit, go_return;

    logic                  disp_start, disp_done;
    logic [NUM_COINS-1:0]  disp_coin;
    logic [TOTAL_BITS-1:0] disp_remaining;

    for (genvar gc = 0; gc < NUM_COINS; gc++) begin : g_coin
        assign value[gc] = TOTAL_BITS'(coin_value(gc));
    end

    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
        logic [STOCK_BITS-1:0] count;
        logic                  restock_hit;
        logic [STOCK_BITS:0]   stock_sum;

        assign price[gi]            = TOTAL_BITS'(item_price(gi));
        assign stock[gi]            = count;
        assign o_sold_out[gi]       = (count == '0);
        assign o_available_item[gi] = (state == ST_IDLE) && (count != '0) && (credit >= price[gi]);

        // Only slots that exist can match, so out-of-range indices fall through.
        assign restock_hit = i_restock_valid && (i_restock_item == IDX_BITS'(gi));
        assign stock_sum   = {1'b0, count} - {{STOCK_BITS{1'b0}}, purchase[gi]}
                           + (restock_hit ? {1'b0, i_restock_qty} : '0);

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                count <= STOCK_BITS'(INIT_STOCK);
            end else if (stock_sum > STOCK_MAX) begin
                count <= '1;
            end else begin
                count <= stock_sum[STOCK_BITS-1:0];
            end
        end
    end

    assign coin_any   = |i_input_coin;
    assign select_any = |i_select_item;
    assign want       = i_select_item & o_available_item;
    assign winner     = want & (~want + NUM_ITEMS'(1));
    assign coin_first = i_input_coin & (~i_input_coin + NUM_COINS'(1));

    always_comb begin
        sel_price = '0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            if (winner[k[IDX_BITS-1:0]]) begin
                sel_price = price[k[IDX_BITS-1:0]];
            end
        end
    end

    always_comb begin
        coin_amt = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (coin_first[k[CIDX_BITS-1:0]]) begin
                coin_amt = value[k[CIDX_BITS-1:0]];
            end
        end
    end

    assign credit_plus = {1'b0, credit} + {1'b0, coin_amt};
    assign coin_ok     = coin_any && (credit_plus <= (TOTAL_BITS + 1)'(MAX_TOTAL));
    assign idle_tick   = (state == ST_IDLE) && (credit != '0) && !coin_any && !select_any && !i_trigger_return;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && idle_tick && (idle_count == TO_LAST);
    assign go_return   = (i_trigger_return || timeout_hit) && (credit != '0);

    vm_change_dispenser #(
        .NUM_COINS  (NUM_COINS),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_dispenser (
        .start          (disp_start),
        .remaining      (credit),
        .coin           (disp_coin),
        .remaining_next (disp_remaining),
        .done           (disp_done)
    );

    always_comb begin
        state_next       = state;
        credit_next      = credit;
        idle_count_next  = '0;
        purchase         = '0;
        output_item_next = '0;
        return_coin_next = '0;
        coin_reject_next = '0;
        return_done_next = 1'b0;
        disp_start       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (coin_ok) begin
                    credit_next = credit_plus[TOTAL_BITS-1:0];
                end else if (coin_any) begin
                    coin_reject_next = coin_first;
                end
                // Purchase is judged on pre-coin credit; a return request wins over it.
                if (!go_return && winner != '0) begin
                    purchase         = winner;
                    output_item_next = winner;
                    credit_next      = credit_next - sel_price;
                end
                if (i_trigger_return && credit == '0) begin
                    return_done_next = 1'b1;
                end
                if (go_return) begin
                    state_next = ST_RETURN;
                end else if (idle_tick) begin
                    idle_count_next = idle_count + TO_BITS'(1);
                end
            end
            ST_RETURN: begin
                disp_start       = 1'b1;
                coin_reject_next = coin_first;
                // A residue no coin can pay out is dropped rather than stalling here.
                if (disp_done) begin
                    return_done_next = 1'b1;
                    credit_next      = '0;
                    state_next       = ST_IDLE;
                end else begin
                    return_coin_next = disp_coin;
                    credit_next      = disp_remaining;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            credit        <= '0;
            idle_count    <= '0;
            o_output_item <= '0;
            o_return_coin <= '0;
            o_coin_reject <= '0;
            o_return_done <= 1'b0;
        end else begin
            state         <= state_next;
            credit        <= credit_next;
            idle_count    <= idle_count_next;
            o_output_item <= output_item_next;
            o_return_coin <= return_coin_next;
            o_coin_reject <= coin_reject_next;
            o_return_done <= return_done_next;
        end
    end

    assign o_current_total = credit;
    assign o_busy          = (state == ST_RETURN);

endmodule

`default_nettype wire
